spike_rate_encoder: RTL
=======================

Name: spike_rate_encoder

Overview:
Input-side rate encoder for the SNN. It accepts one sample of NUM_INPUTS pixel intensities over a valid/ready handshake, then presents them for WINDOW_LEN cycles as a per-input spike train. Spike probability per cycle is proportional to intensity. The output-side winner-selection counter consumes the network's response to these trains.

Parameters:
NUM_INPUTS, 1, number of input pixels / spike lines
PIX_W, 8, pixel intensity width (1..16)
WINDOW_LEN, 256, presentation window length in cycles (>=1)
LFSR_SEED, 16'hACE1, base seed; input i seeded with LFSR_SEED + i (a result of 0 is replaced by 1)

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
pix_valid_i  in  1  sample valid
pix_ready_o  out  1  encoder can accept a sample
pix_data_i  in  NUM_INPUTS*PIX_W  packed intensities; input i at [i*PIX_W +: PIX_W]
abort_i  in  1  terminate the current window
spikes_o  out  NUM_INPUTS  spike per input, this cycle
spike_valid_o  out  1  spikes_o is part of an active window
done_o  out  1  one-cycle pulse on the final window cycle

Behaviour:
- Clocking and reset: one clock (clk_i); reset rst_ni is asynchronous, active-low. While in reset:
  - all state clears and every LFSR reloads its seed;
  - spikes_o=0, spike_valid_o=0, done_o=0, pix_ready_o=0.
  - Idle state is entered asynchronously, so pix_ready_o=1 from the first cycle after release.
- FSM states: IDLE, PRESENT.
  - IDLE: pix_ready_o=1. On pix_valid_i&&pix_ready_o, pix_data_i is captured into pix_q, the cycle counter t is set to 0, and the FSM moves to PRESENT.
  - PRESENT: pix_ready_o=0. pix_valid_i and pix_data_i are ignored.
- Output timing: spikes_o, spike_valid_o and done_o are combinational from registered state. Latency from accept to first spike cycle is 1 cycle.
- In PRESENT:
  - spike_valid_o=1.
  - spikes_o[i] = (lfsr_i[PIX_W-1:0] < pix_q[i]).
  - Each LFSR steps once per PRESENT cycle; t increments.
  - On t==WINDOW_LEN-1: done_o=1 and the next state is IDLE.
  - Outside PRESENT: spikes_o=0, spike_valid_o=0.
- LFSR: 16-bit Galois, taps mask 16'hB400, right shift. The LFSR is not reseeded between samples, only on reset.
- Intensity bounds: pix=0 never spikes. Maximum intensity spikes on every cycle except when the LFSR low bits are all ones.
- abort_i in PRESENT: next state is IDLE, with no done_o for that window. If abort_i coincides with the final cycle, done_o still shows 1 in that cycle, because it is combinational on t. abort_i in IDLE has no effect.
- Counter width: $clog2(WINDOW_LEN+1). t never wraps, because it leaves PRESENT at WINDOW_LEN-1.
- Back-to-back samples: the earliest next accept is the cycle after done_o, so there is one idle cycle between windows.

Optional Feature:
Macro SPIKE_ENC_DETERMINISTIC_EN.
- Defined: the LFSRs are replaced by per-input PIX_W-bit phase accumulators.
  - Accumulators clear on accept.
  - Each PRESENT cycle: {carry,acc_i} = acc_i + pix_q[i], and spikes_o[i] = carry for that cycle's addition.
  - Spike count over a WINDOW_LEN = 2^PIX_W window equals pix exactly.
  - LFSR_SEED is unused.
- Undefined: stochastic LFSR behaviour as above.
- Handshake and FSM are identical in both builds.

Decomposition:
- Package snn_enc_pkg holds:
  - enc_state_t enum (ENC_IDLE, ENC_PRESENT);
  - LFSR_W=16 and LFSR_TAPS=16'hB400;
  - function lfsr_next().
- One natural sub-module, spike_lfsr: parameter SEED; ports clk_i, rst_ni, step_i, value_o. It is instantiated per input in a generate loop and compiled out under SPIKE_ENC_DETERMINISTIC_EN.

Test Plan:
- Reset: assert rst_ni low mid-clock -> all outputs 0 immediately; pix_ready_o=1 in the first cycle after release.
- Deterministic build, NUM_INPUTS=4, pix={0,64,255,128}, WINDOW_LEN=256 -> spike counts {0,64,255,128}. spike_valid_o is high exactly 256 cycles. done_o pulses once, on the 256th cycle. pix_ready_o=1 on the following cycle.
- LFSR build, pix={0,255}, seed 16'hACE1 -> input0 never spikes; input1 per-cycle spikes match the reference-model LFSR sequence bit-exactly.
- Hold pix_valid_i=1 and change pix_data_i during PRESENT -> no second accept (pix_ready_o=0), and spike behaviour follows the originally captured value.
- abort_i at t=10 -> spike_valid_o=0 from t=11 onward, no done_o, pix_ready_o=1 at t=11. A new sample is accepted at t=11.
- LFSR build, drop rst_ni at t=100 and restart with the same pixels -> the spike train reproduces the first 100 cycles identically, confirming reseed on reset.

Source files
------------

// File: rtl/snn_enc_pkg.sv
// Shared types and LFSR helpers for the spike rate encoder.
package snn_enc_pkg;

  typedef enum logic [0:0] {
    ENC_IDLE,
    ENC_PRESENT
  } enc_state_t;

  localparam int unsigned       LFSR_W    = 16;
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;

  // Galois form, right shift: the bit shifted out selects the tap mask.
  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
    return s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
  endfunction

endpackage

// File: rtl/spike_lfsr.sv
// 16-bit Galois LFSR that advances on step_i; reloads SEED only on reset.
module spike_lfsr
  import snn_enc_pkg::*;
#(
  parameter logic [LFSR_W-1:0] SEED = 16'hACE1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              step_i,
  output logic [LFSR_W-1:0] value_o
);

  logic [LFSR_W-1:0] lfsr_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lfsr_q <= SEED;
    end else if (step_i) begin
      lfsr_q <= lfsr_next(lfsr_q);
    end
  end

  assign value_o = lfsr_q;

endmodule

// File: rtl/spike_rate_encoder.sv
// Rate encoder: presents one captured sample as per-input spike trains for WINDOW_LEN cycles.
// Define SPIKE_ENC_DETERMINISTIC_EN to use phase accumulators instead of LFSRs.
module spike_rate_encoder
  import snn_enc_pkg::*;
#(
  parameter int unsigned       NUM_INPUTS = 1,
  parameter int unsigned       PIX_W      = 8,
  parameter int unsigned       WINDOW_LEN = 256,
  parameter logic [LFSR_W-1:0] LFSR_SEED  = 16'hACE1
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        pix_valid_i,
  output logic                        pix_ready_o,
  input  logic [NUM_INPUTS*PIX_W-1:0] pix_data_i,
  input  logic                        abort_i,
  output logic [NUM_INPUTS-1:0]       spikes_o,
  output logic                        spike_valid_o,
  output logic                        done_o
);

  localparam int unsigned     CntW  = $clog2(WINDOW_LEN + 1);
  localparam logic [CntW-1:0] TLast = CntW'(WINDOW_LEN - 1);

  enc_state_t                  state_q, state_d;
  logic [CntW-1:0]             t_q, t_d;
  logic [NUM_INPUTS*PIX_W-1:0] pix_q, pix_d;
  logic                        accept, present, last;

  assign present       = (state_q == ENC_PRESENT);
  assign last          = present && (t_q == TLast);
  // Held low during reset even though the state register already reads idle.
  assign pix_ready_o   = rst_ni && (state_q == ENC_IDLE);
  assign accept        = pix_valid_i && pix_ready_o;
  assign spike_valid_o = present;
  assign done_o        = last;

  always_comb begin
    state_d = state_q;
    t_d     = t_q;
    pix_d   = pix_q;
    unique case (state_q)
      ENC_IDLE: begin
        if (accept) begin
          state_d = ENC_PRESENT;
          t_d     = '0;
          pix_d   = pix_data_i;
        end
      end
      ENC_PRESENT: begin
        t_d = t_q + 1'b1;
        if (abort_i || last) begin
          state_d = ENC_IDLE;
        end
      end
      default: state_d = ENC_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ENC_IDLE;
      t_q     <= '0;
      pix_q   <= '0;
    end else begin
      state_q <= state_d;
      t_q     <= t_d;
      pix_q   <= pix_d;
    end
  end

  for (genvar i = 0; i < NUM_INPUTS; i++) begin : g_lane
    logic [PIX_W-1:0] pix_i;
    assign pix_i = pix_q[i*PIX_W +: PIX_W];

`ifdef SPIKE_ENC_DETERMINISTIC_EN
    logic [PIX_W-1:0] acc_q;
    logic [PIX_W:0]   sum;

    assign sum         = {1'b0, acc_q} + {1'b0, pix_i};
    assign spikes_o[i] = present && sum[PIX_W];

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        acc_q <= '0;
      end else if (accept) begin
        acc_q <= '0;
      end else if (present) begin
        acc_q <= sum[PIX_W-1:0];
      end
    end
`else
    localparam logic [LFSR_W-1:0] SeedRaw = LFSR_W'(LFSR_SEED + i);
    localparam logic [LFSR_W-1:0] Seed    = (SeedRaw == '0) ? LFSR_W'(1) : SeedRaw;
    localparam logic [LFSR_W-1:0] LoMask  = LFSR_W'((32'd1 << PIX_W) - 32'd1);

    logic [LFSR_W-1:0] lfsr_val;

    spike_lfsr #(
      .SEED(Seed)
    ) u_lfsr (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .step_i (present),
      .value_o(lfsr_val)
    );

    // Only the low PIX_W bits of the LFSR take part in the comparison.
    assign spikes_o[i] = present && ((lfsr_val & LoMask) < LFSR_W'(pix_i));
`endif
  end

endmodule
